// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin valid/ready arbiter for the register file
// write port with a post-reset/on-command clear sequencer.
// Optional: define REGFILE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    input  logic             clear_start,
    output logic             busy,
    output logic             we3,
    output logic [AW-1:0]    wa3,
    output logic [DW-1:0]    wd3,
    output logic [2:0]       grant_id
);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [2:0]      ptr_q, ptr_d;
    logic            we3_q, we3_d;
    logic [AW-1:0]   wa3_q, wa3_d;
    logic [DW-1:0]   wd3_q, wd3_d;
    logic [2:0]      gid_q, gid_d;

    logic [2:0]      win;
    logic            any;
    logic            accept;

    // Winner search: scan from the start point upward, keep the first hit.
    always_comb begin
        int idx;
        win = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr_q) + k) % NREQ;
`endif
            if (req_valid[idx]) begin
                win = 3'(idx);
                any = 1'b1;
            end
        end
    end

    assign accept    = (state_q == IDLE) && !clear_start && any;
    assign req_ready = accept ? (NREQ'(1) << win) : '0;
    assign busy      = (state_q == CLEAR);

    // Next-state and registered write-port values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we3_d   = 1'b0;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        gid_d   = gid_q;
        unique case (state_q)
            CLEAR: begin
                we3_d = 1'b1;
                wa3_d = cnt_q;
                wd3_d = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (any) begin
                    we3_d = 1'b1;
                    wa3_d = req_addr[int'(win)*AW +: AW];
                    wd3_d = req_data[int'(win)*DW +: DW];
                    gid_d = win;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
                    ptr_d = (int'(win) == NREQ - 1) ? 3'd0 : win + 3'd1;
`endif
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ptr_q   <= '0;
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
            gid_q   <= gid_d;
        end
    end

    assign we3      = we3_q;
    assign wa3      = wa3_q;
    assign wd3      = wd3_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed + randomized checks of the write arbiter
// against a behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 1 << AW;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             clear_start;
    logic             busy;
    logic             we3;
    logic [AW-1:0]    wa3;
    logic [DW-1:0]    wd3;
    logic [2:0]       grant_id;

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .clear_start(clear_start), .busy(busy),
        .we3(we3), .wa3(wa3), .wd3(wd3), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: clearing flag with next address, rotating pointer, last write.
    bit m_clearing;
    int m_next_addr;
    int m_ptr;
    int m_we, m_wa, m_wd, m_gid;

    logic [NREQ-1:0] obs_ready;
    logic            obs_busy;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_clearing = 1'b1;
        m_next_addr = 0;
        m_ptr = 0;
        m_we = 0; m_wa = 0; m_wd = 0; m_gid = 0;
    endtask

    // Return the winning requester, or -1 when nobody is valid.
    function automatic int model_winner();
        int start;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock: check combinational outputs, clock, advance model, check registers.
    task automatic cycle();
        int w;
        int exp_ready;
        #1;
        w = model_winner();
        exp_ready = (!m_clearing && !clear_start && w >= 0) ? (1 << w) : 0;
        obs_ready = req_ready;
        obs_busy  = busy;
        check("req_ready", int'(req_ready), exp_ready);
        check("busy", int'(busy), int'(m_clearing));
        @(posedge clk);
        if (m_clearing) begin
            m_we = 1; m_wa = m_next_addr; m_wd = 0;
            m_next_addr++;
            if (m_next_addr == NREG) begin
                m_clearing = 1'b0;
                m_next_addr = 0;
            end
        end else if (clear_start) begin
            m_clearing = 1'b1;
            m_next_addr = 0;
            m_we = 0;
        end else if (w >= 0) begin
            m_we = 1;
            m_wa = int'(req_addr[w*AW +: AW]);
            m_wd = int'(req_data[w*DW +: DW]);
            m_gid = w;
            m_ptr = (w + 1) % NREQ;
        end else begin
            m_we = 0;
        end
        #1;
        check("we3", int'(we3), m_we);
        check("wa3", int'(wa3), m_wa);
        check("wd3", int'(wd3), m_wd);
        check("grant_id", int'(grant_id), m_gid);
    endtask

    task automatic set_req(input int i, input int a, input int d);
        req_valid[i] = 1'b1;
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*DW +: DW] = DW'(d);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        clear_start = 1'b0;
        model_reset();
        #2;
        check("rst_we3", int'(we3), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_ready", int'(req_ready), 0);
        check("rst_wa3", int'(wa3), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clear after reset: addresses 0..7, data 0.
        for (int i = 0; i < NREG; i++) begin
            cycle();
            check("clr_we3_lit", int'(we3), 1);
            check("clr_wa3_lit", int'(wa3), i);
            check("clr_wd3_lit", int'(wd3), 0);
        end
        cycle();
        check("post_clr_busy_lit", int'(busy), 0);
        check("post_clr_we3_lit", int'(we3), 0);

        // Single requester 2.
        set_req(2, 5, 8'hA7);
        cycle();
        check("r2_ready_lit", int'(obs_ready), 4);
        check("r2_we3_lit", int'(we3), 1);
        check("r2_wa3_lit", int'(wa3), 5);
        check("r2_wd3_lit", int'(wd3), 8'hA7);
        check("r2_gid_lit", int'(grant_id), 2);
        req_valid = '0;

        // Bring pointer back to 0 by granting requester 3 alone.
        set_req(3, 1, 8'h11);
        cycle();
        req_valid = '0;

        // All four valid for 8 cycles.
        for (int i = 0; i < NREQ; i++) set_req(i, i + 2, 16 * i + 3);
        for (int c = 0; c < 8; c++) begin
            cycle();
            check("rr_we3_lit", int'(we3), 1);
`ifndef REGFILE_ARB_FIXED_PRIO_EN
            check("rr_gid_lit", int'(grant_id), c % NREQ);
`endif
        end
        req_valid = '0;

        // clear_start wins over a valid request.
        set_req(1, 6, 8'h5C);
        clear_start = 1'b1;
        cycle();
        check("cs_ready_lit", int'(obs_ready), 0);
        clear_start = 1'b0;
        for (int c = 0; c < NREG; c++) begin
            cycle();
            check("cs_busy_lit", int'(obs_busy), 1);
        end
        cycle();
        check("cs_idle_ready_lit", int'(obs_ready), 2);
        check("cs_idle_gid_lit", int'(grant_id), 1);
        req_valid = '0;

        // Async reset mid-clear after address 3 has been issued.
        clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        check("pre_rst_wa3_lit", int'(wa3), 3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_we3_lit", int'(we3), 0);
        check("arst_busy_lit", int'(busy), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check("arst_restart_wa3_lit", int'(wa3), 0);
        check("arst_restart_we3_lit", int'(we3), 1);
        for (int c = 1; c < NREG; c++) cycle();

`ifdef REGFILE_ARB_FIXED_PRIO_EN
        set_req(1, 2, 8'h21);
        set_req(3, 4, 8'h43);
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("fp_gid_lit", int'(grant_id), 1);
        end
        req_valid = '0;
`endif

        // Randomized traffic; a waiting requester usually holds its request.
        for (int c = 0; c < 400; c++) begin
            logic [NREQ-1:0] granted;
            granted = obs_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !granted[i] && $urandom_range(0, 9) < 8) begin
                    // keep holding
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, 255)));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            clear_start = ($urandom_range(0, 39) == 0);
            cycle();
        end
        clear_start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
